tile_result_writeback: RTL and testbench



---
 rtl/tile_result_writeback.sv | 222 ++++++++++++++++++++++
 tb/tb_tile_result_writeback.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_result_writeback.sv
// tile_result_writeback
//   Captures one finished ROW_NUM x ROW_NUM result tile from the systolic
//   array (one row per data_output_valid beat), then drains it element by
//   element, row-major, to result memory over a valid/ready write port.
//   Global addresses are gr*N_SIZE + gc, where the tile position
//   (tile_r, tile_c) advances row-major across all output tiles. Elements
//   that fall outside the M_SIZE x N_SIZE matrix are skipped (one cycle each,
//   no write).
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   data_output_valid   row_data holds a valid result row this cycle
//   row_data            one result row, column c at [c*DATA_W +: DATA_W]
//   tile_clr            zero tile position; aborts a tile in progress
//   wr_ready            memory accepts the write this cycle
//   wr_valid/addr/data  write request (decoded from registered state only)
//   busy                high while capturing or draining
//   tile_done           one-cycle pulse after a tile finishes draining
//   all_done            coincident with tile_done for the last tile
//   overflow_err        sticky: a row arrived while draining (row dropped)
//
// Build option
//   RESULT_RELU_EN      when defined, negative results are written as 0.
module tile_result_writeback #(
  parameter int ROW_NUM = 4,
  parameter int DATA_W  = 16,
  parameter int M_SIZE  = 4,
  parameter int N_SIZE  = 4,
  parameter int ADDR_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      data_output_valid,
  input  logic [ROW_NUM*DATA_W-1:0] row_data,
  input  logic                      tile_clr,
  input  logic                      wr_ready,
  output logic                      wr_valid,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      busy,
  output logic                      tile_done,
  output logic                      all_done,
  output logic                      overflow_err
);

  localparam int TILES_M = (M_SIZE + ROW_NUM - 1) / ROW_NUM;
  localparam int TILES_N = (N_SIZE + ROW_NUM - 1) / ROW_NUM;
  localparam int ELEMS   = ROW_NUM * ROW_NUM;
  localparam int RI_W    = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam int EC_W    = (ELEMS > 1)   ? $clog2(ELEMS)   : 1;
  localparam int TR_W    = (TILES_M > 1) ? $clog2(TILES_M) : 1;
  localparam int TC_W    = (TILES_N > 1) ? $clog2(TILES_N) : 1;

  localparam logic [RI_W-1:0] ROW_LAST  = RI_W'(ROW_NUM - 1);
  localparam logic [EC_W-1:0] ELEM_LAST = EC_W'(ELEMS - 1);
  localparam logic [TR_W-1:0] TR_LAST   = TR_W'(TILES_M - 1);
  localparam logic [TC_W-1:0] TC_LAST   = TC_W'(TILES_N - 1);

  // The whole matrix must be addressable.
  if (longint'(M_SIZE) * longint'(N_SIZE) > (longint'(1) << ADDR_W)) begin : g_bad_cfg
    $error("tile_result_writeback: M_SIZE*N_SIZE exceeds 2**ADDR_W");
  end

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_e;

  state_e                    state_q, state_d;
  logic [RI_W-1:0]           row_cnt_q, row_cnt_d;
  logic [EC_W-1:0]           elem_cnt_q, elem_cnt_d;
  logic [TR_W-1:0]           tile_r_q, tile_r_d;
  logic [TC_W-1:0]           tile_c_q, tile_c_d;
  logic                      tile_done_q, tile_done_d;
  logic                      all_done_q, all_done_d;
  logic                      ovf_q, ovf_d;
  logic [ROW_NUM*DATA_W-1:0] buf_q [ROW_NUM];
  logic                      buf_we;
  logic [RI_W-1:0]           buf_row;

  // Element currently presented in DRAIN.
  logic [RI_W-1:0]           r_idx, c_idx;
  logic [ROW_NUM*DATA_W-1:0] row_sel;
  logic [DATA_W-1:0]         elem;
  int                        gr, gc;
  logic                      in_range;

  assign r_idx    = RI_W'(elem_cnt_q / EC_W'(ROW_NUM));
  assign c_idx    = RI_W'(elem_cnt_q % EC_W'(ROW_NUM));
  assign row_sel  = buf_q[r_idx];
  assign gr       = int'(tile_r_q) * ROW_NUM + int'(r_idx);
  assign gc       = int'(tile_c_q) * ROW_NUM + int'(c_idx);
  assign in_range = (gr < M_SIZE) && (gc < N_SIZE);

  always_comb begin
    elem = '0;
    for (int c = 0; c < ROW_NUM; c++) begin
      if (c_idx == RI_W'(c)) elem = row_sel[c*DATA_W +: DATA_W];
    end
  end

  // Write port is a pure decode of registered state so it stays stable
  // while the memory stalls.
  always_comb begin
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    if (state_q == S_DRAIN && in_range) begin
      wr_valid = 1'b1;
      wr_addr  = ADDR_W'(gr * N_SIZE + gc);
`ifdef RESULT_RELU_EN
      wr_data  = elem[DATA_W-1] ? '0 : elem;
`else
      wr_data  = elem;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    elem_cnt_d  = elem_cnt_q;
    tile_r_d    = tile_r_q;
    tile_c_d    = tile_c_q;
    tile_done_d = 1'b0;
    all_done_d  = 1'b0;
    ovf_d       = ovf_q;
    buf_we      = 1'b0;
    buf_row     = row_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (data_output_valid) begin
          buf_we    = 1'b1;
          buf_row   = '0;
          row_cnt_d = (ROW_NUM == 1) ? '0 : RI_W'(1);
          state_d   = (ROW_NUM == 1) ? S_DRAIN : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (data_output_valid) begin
          buf_we = 1'b1;
          if (row_cnt_q == ROW_LAST) begin
            row_cnt_d = '0;
            state_d   = S_DRAIN;
          end else begin
            row_cnt_d = row_cnt_q + RI_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // Buffer is in use: a new row here is lost.
        if (data_output_valid) ovf_d = 1'b1;
        // Out-of-range elements are skipped without a handshake.
        if (!in_range || wr_ready) begin
          if (elem_cnt_q == ELEM_LAST) begin
            elem_cnt_d  = '0;
            state_d     = S_IDLE;
            tile_done_d = 1'b1;
            if (tile_c_q == TC_LAST) begin
              tile_c_d = '0;
              if (tile_r_q == TR_LAST) begin
                tile_r_d   = '0;
                all_done_d = 1'b1;
              end else begin
                tile_r_d = tile_r_q + TR_W'(1);
              end
            end else begin
              tile_c_d = tile_c_q + TC_W'(1);
            end
          end else begin
            elem_cnt_d = elem_cnt_q + EC_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // New matrix: restart tile positions and drop any partial tile.
    if (tile_clr) begin
      tile_r_d = '0;
      tile_c_d = '0;
      if (state_q != S_IDLE) begin
        state_d     = S_IDLE;
        row_cnt_d   = '0;
        elem_cnt_d  = '0;
        tile_done_d = 1'b0;
        all_done_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_cnt_q   <= '0;
      elem_cnt_q  <= '0;
      tile_r_q    <= '0;
      tile_c_q    <= '0;
      tile_done_q <= 1'b0;
      all_done_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      elem_cnt_q  <= elem_cnt_d;
      tile_r_q    <= tile_r_d;
      tile_c_q    <= tile_c_d;
      tile_done_q <= tile_done_d;
      all_done_q  <= all_done_d;
      ovf_q       <= ovf_d;
    end
  end

  // Tile buffer needs no reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[buf_row] <= row_data;
  end

  assign busy         = (state_q != S_IDLE);
  assign tile_done    = tile_done_q;
  assign all_done     = all_done_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_tile_result_writeback.sv
// Bench for tile_result_writeback: a 4x4 instance (single tile per matrix)
// and a 6x6 instance (four tiles, partially out of range). Expected writes
// come from a queue filled from the matrix/tile arithmetic.
module tb_tile_result_writeback;

  typedef logic [3:0][3:0][15:0] tile_t;
  typedef struct packed { logic [7:0] addr; logic [15:0] data; } wr_t;
  typedef struct packed {
    tile_t      v;
    logic [3:0] pat;
    int         exp_done_k;
    int         exp_vld;
    int         exp_sum;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dov  [2];
  logic [63:0] row  [2];
  logic        clr  [2];
  logic        rdy  [2];
  logic        vld  [2];
  logic [7:0]  addr [2];
  logic [15:0] data [2];
  logic        busy [2];
  logic        tdone[2];
  logic        adone[2];
  logic        ovf  [2];

  int total = 0;
  int bad   = 0;
  int ntd[2], nad[2], nvld[2], sum[2];
  wr_t qa[$];
  wr_t qb[$];

  always #5 clk = ~clk;

  tile_result_writeback #(.ROW_NUM(4), .DATA_W(16), .M_SIZE(4), .N_SIZE(4), .ADDR_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_output_valid(dov[0]), .row_data(row[0]),
    .tile_clr(clr[0]), .wr_ready(rdy[0]), .wr_valid(vld[0]), .wr_addr(addr[0]),
    .wr_data(data[0]), .busy(busy[0]), .tile_done(tdone[0]), .all_done(adone[0]),
    .overflow_err(ovf[0]));

  tile_result_writeback #(.ROW_NUM(4), .DATA_W(16), .M_SIZE(6), .N_SIZE(6), .ADDR_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_output_valid(dov[1]), .row_data(row[1]),
    .tile_clr(clr[1]), .wr_ready(rdy[1]), .wr_valid(vld[1]), .wr_addr(addr[1]),
    .wr_data(data[1]), .busy(busy[1]), .tile_done(tdone[1]), .all_done(adone[1]),
    .overflow_err(ovf[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int qsize(int d);
    return (d == 0) ? qa.size() : qb.size();
  endfunction

  function automatic wr_t qfront(int d);
    return (d == 0) ? qa[0] : qb[0];
  endfunction

  task automatic qpop(int d);
    if (d == 0) void'(qa.pop_front()); else void'(qb.pop_front());
  endtask

  task automatic qpush(int d, wr_t w);
    if (d == 0) qa.push_back(w); else qb.push_back(w);
  endtask

  function automatic logic [15:0] model_data(logic [15:0] x);
`ifdef RESULT_RELU_EN
    return ($signed(x) < 0) ? 16'd0 : x;
`else
    return x;
`endif
  endfunction

  // Reference: every in-range element of tile (tr,tc), row-major.
  task automatic expect_tile(int d, int tr, int tc, tile_t v);
    int msz;
    int gr, gc;
    wr_t w;
    msz = (d == 0) ? 4 : 6;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        gr = tr * 4 + r;
        gc = tc * 4 + c;
        if (gr < msz && gc < msz) begin
          w.addr = 8'(gr * msz + gc);
          w.data = model_data(v[r][c]);
          qpush(d, w);
        end
      end
    end
  endtask

  // One clock: sample both DUTs mid-cycle, then step past the next edge.
  task automatic cyc();
    wr_t e;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (vld[d]) begin
        nvld[d]++;
        if (qsize(d) == 0) begin
          chk("wr_unexpected", 32'(vld[d]), 32'd0);
        end else begin
          e = qfront(d);
          chk("wr_addr", 32'(addr[d]), 32'(e.addr));
          chk("wr_data", 32'(data[d]), 32'(e.data));
          if (rdy[d]) begin
            qpop(d);
            sum[d] += int'(data[d]);
          end
        end
      end else if (!busy[d]) begin
        chk("idle_addr", 32'(addr[d]), 32'd0);
        chk("idle_data", 32'(data[d]), 32'd0);
      end
      if (tdone[d]) ntd[d]++;
      if (adone[d]) begin
        nad[d]++;
        chk("all_done_with_tile_done", 32'(tdone[d]), 32'd1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed(int d, tile_t v, bit gaps);
    for (int r = 0; r < 4; r++) begin
      dov[d] = 1'b1;
      row[d] = v[r];
      cyc();
      dov[d] = 1'b0;
      chk("busy_capture", 32'(busy[d]), 32'd1);
      if (gaps && r < 3) repeat ($urandom_range(0, 2)) cyc();
    end
  endtask

  // Drain until tile_done is seen; kdone = drain cycle index of the pulse.
  task automatic drain(int d, logic [3:0] pat, bit rnd, int ovf_k, output int kdone);
    int t0;
    t0    = ntd[d];
    kdone = -1;
    for (int k = 0; k < 200; k++) begin
      rdy[d] = rnd ? 1'($urandom_range(0, 1)) : pat[2'(k)];
      dov[d] = (k == ovf_k);
      row[d] = 64'hDEAD_BEEF_0BAD_F00D;
      cyc();
      if (ntd[d] != t0) begin
        kdone = k;
        break;
      end
    end
    dov[d] = 1'b0;
    rdy[d] = 1'b1;
    chk("tile_done_count", 32'(ntd[d]), 32'(t0 + 1));
    chk("busy_after_done", 32'(busy[d]), 32'd0);
    chk("model_drained", 32'(qsize(d)), 32'd0);
  endtask

  initial begin
    vec_t  tbl[3];
    tile_t v, v7;
    int    k, t0, a0, v0, s0;
    int    exp_vld_b[4];
    int    exp_ad_b[4];

    for (int d = 0; d < 2; d++) begin
      dov[d] = 1'b0; row[d] = '0; clr[d] = 1'b0; rdy[d] = 1'b1;
      ntd[d] = 0; nad[d] = 0; nvld[d] = 0; sum[d] = 0;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        tbl[0].v[r][c] = 16'(r * 4 + c + 1);
        tbl[1].v[r][c] = 16'(r * 4 + c + 1);
        tbl[2].v[r][c] = 16'd7;
        v7[r][c]       = 16'd7;
      end
    tbl[0].pat = 4'b1111; tbl[0].exp_done_k = 16; tbl[0].exp_vld = 16; tbl[0].exp_sum = 136;
    tbl[1].pat = 4'b1001; tbl[1].exp_done_k = 32; tbl[1].exp_vld = 32; tbl[1].exp_sum = 136;
    tbl[2].pat = 4'b0101; tbl[2].exp_done_k = 31; tbl[2].exp_vld = 31; tbl[2].exp_sum = 112;
    exp_vld_b = '{16, 8, 8, 4};
    exp_ad_b  = '{0, 0, 0, 1};

    // Reset state
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_wr_valid", 32'(vld[d]), 32'd0);
      chk("rst_busy", 32'(busy[d]), 32'd0);
      chk("rst_tile_done", 32'(tdone[d]), 32'd0);
      chk("rst_all_done", 32'(adone[d]), 32'd0);
      chk("rst_overflow", 32'(ovf[d]), 32'd0);
      chk("rst_addr", 32'(addr[d]), 32'd0);
      chk("rst_data", 32'(data[d]), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table: single 4x4 tile with different ready patterns
    for (int i = 0; i < 3; i++) begin
      t0 = ntd[0]; a0 = nad[0]; v0 = nvld[0]; s0 = sum[0];
      expect_tile(0, 0, 0, tbl[i].v);
      feed(0, tbl[i].v, 1'b0);
      drain(0, tbl[i].pat, 1'b0, -1, k);
      chk("done_cycle", 32'(k), 32'(tbl[i].exp_done_k));
      chk("valid_cycles", 32'(nvld[0] - v0), 32'(tbl[i].exp_vld));
      chk("data_sum", 32'(sum[0] - s0), 32'(tbl[i].exp_sum));
      chk("all_done_count", 32'(nad[0] - a0), 32'd1);
    end

    // Negative values
    v = '0;
    v[0][0] = 16'hFFFD; v[0][1] = 16'd0; v[0][2] = 16'd5; v[0][3] = 16'hFFFF;
    s0 = sum[0];
    expect_tile(0, 0, 0, v);
    feed(0, v, 1'b0);
    drain(0, 4'b1111, 1'b0, -1, k);
`ifdef RESULT_RELU_EN
    chk("relu_sum", 32'(sum[0] - s0), 32'd5);
`else
    chk("raw_sum", 32'(sum[0] - s0), 32'd131073);
`endif

    // Random data, row gaps and random ready
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) v[r][c] = 16'($urandom);
      a0 = nad[0];
      expect_tile(0, 0, 0, v);
      feed(0, v, 1'b1);
      drain(0, 4'b0000, 1'b1, -1, k);
      chk("rand_all_done", 32'(nad[0] - a0), 32'd1);
    end

    // 6x6 matrix: four tiles, edge tiles partially skipped
    for (int t = 0; t < 4; t++) begin
      a0 = nad[1]; v0 = nvld[1];
      expect_tile(1, t / 2, t % 2, v7);
      feed(1, v7, 1'b0);
      drain(1, 4'b1111, 1'b0, -1, k);
      chk("b_done_cycle", 32'(k), 32'd16);
      chk("b_valid_cycles", 32'(nvld[1] - v0), 32'(exp_vld_b[t]));
      chk("b_all_done", 32'(nad[1] - a0), 32'(exp_ad_b[t]));
    end

    // tile_clr mid-capture: abort, and restart at tile (0,0)
    expect_tile(1, 0, 0, v7);
    feed(1, v7, 1'b0);
    drain(1, 4'b1111, 1'b0, -1, k);
    t0 = ntd[1];
    for (int r = 0; r < 2; r++) begin
      dov[1] = 1'b1; row[1] = v7[r]; cyc();
    end
    dov[1] = 1'b0; clr[1] = 1'b1; cyc(); clr[1] = 1'b0;
    chk("clr_busy", 32'(busy[1]), 32'd0);
    cyc();
    chk("clr_no_tile_done", 32'(ntd[1]), 32'(t0));
    v0 = nvld[1];
    expect_tile(1, 0, 0, v7);
    feed(1, v7, 1'b0);
    drain(1, 4'b1111, 1'b0, -1, k);
    chk("clr_restart_valid", 32'(nvld[1] - v0), 32'd16);

    // Row during DRAIN: sticky error, drain unaffected
    chk("ovf_before", 32'(ovf[0]), 32'd0);
    s0 = sum[0];
    expect_tile(0, 0, 0, tbl[0].v);
    feed(0, tbl[0].v, 1'b0);
    drain(0, 4'b1111, 1'b0, 3, k);
    chk("ovf_done_cycle", 32'(k), 32'd16);
    chk("ovf_sum", 32'(sum[0] - s0), 32'd136);
    chk("ovf_set", 32'(ovf[0]), 32'd1);
    expect_tile(0, 0, 0, tbl[0].v);
    feed(0, tbl[0].v, 1'b0);
    drain(0, 4'b1111, 1'b0, -1, k);
    chk("ovf_sticky", 32'(ovf[0]), 32'd1);

    // Reset at element 5 of tile (0,1) on the 6x6 instance
    expect_tile(1, 0, 1, v7);
    feed(1, v7, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rdy[1] = 1'b1;
      cyc();
    end
    chk("pre_reset_left", 32'(qb.size()), 32'd5);
    qb.delete();
    rdy[1] = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    rdy[1] = 1'b1;
    @(negedge clk);
    chk("post_rst_wr_valid", 32'(vld[1]), 32'd0);
    chk("post_rst_busy", 32'(busy[1]), 32'd0);
    chk("post_rst_addr", 32'(addr[1]), 32'd0);
    chk("post_rst_ovf_a", 32'(ovf[0]), 32'd0);
    @(posedge clk); #1;
    v0 = nvld[1];
    expect_tile(1, 0, 0, v7);
    feed(1, v7, 1'b0);
    drain(1, 4'b1111, 1'b0, -1, k);
    chk("post_rst_valid", 32'(nvld[1] - v0), 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
